// File: rtl/rc4_prga_if.sv
// Shared S-box memory port, keystream stream and control handshake of the RC4 PRGA stage.
interface rc4_prga_if;
    logic        ksa_done;
    logic [15:0] ks_len;
    logic [7:0]  S_rd_addr;
    logic [7:0]  S_rd_data;
    logic [7:0]  S_addr_a;
    logic [7:0]  S_addr_b;
    logic        S_swap;
    logic [7:0]  ks_data;
    logic        ks_valid;
    logic        ks_ready;
    logic        prga_done;

    modport master (
        input  ksa_done, ks_len, S_rd_data, ks_ready,
        output S_rd_addr, S_addr_a, S_addr_b, S_swap, ks_data, ks_valid, prga_done
    );

    modport slave (
        output ksa_done, ks_len, S_rd_data, ks_ready,
        input  S_rd_addr, S_addr_a, S_addr_b, S_swap, ks_data, ks_valid, prga_done
    );
endinterface

// File: rtl/rc4_prga.sv
// RC4 keystream generator: walks i/j over the shared S-box and streams ks_len bytes.
// Optional RC4_DROP_EN macro discards the first DROP_N generated bytes.
module rc4_prga #(
    parameter int unsigned DROP_N = 256
) (
    input  logic         clk,
    input  logic         rst,
    rc4_prga_if.master   io_bus
);
    localparam int unsigned BW = 8;
    localparam int unsigned CW = 16;

    typedef enum logic [3:0] {
        ST_IDLE, ST_I, ST_J, ST_JR, ST_SWAP, ST_T, ST_K, ST_OUT, ST_DONE
    } state_t;

    state_t        r_state, w_state_n;
    logic [BW-1:0] r_i, r_j, r_si, r_t;
    logic [BW-1:0] w_i_n, w_j_n, w_si_n, w_t_n;
    logic [CW-1:0] r_cnt, r_len, w_cnt_n, w_len_n;
    logic [BW-1:0] r_rd_addr, r_addr_a, r_addr_b, r_ks_data;
    logic [BW-1:0] w_rd_addr_n, w_addr_a_n, w_addr_b_n, w_ks_data_n;
    logic          r_swap, r_ks_valid, r_done;
    logic          w_swap_n, w_ks_valid_n, w_done_n;
    logic          w_drop_now;

`ifdef RC4_DROP_EN
    logic [CW-1:0] r_drop, w_drop_n;

    assign w_drop_now = (r_drop != '0);

    always_comb begin
        w_drop_n = r_drop;
        if (r_state == ST_IDLE && io_bus.ksa_done)
            w_drop_n = CW'(DROP_N);
        else if (r_state == ST_K && w_drop_now)
            w_drop_n = r_drop - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) r_drop <= '0;
        else     r_drop <= w_drop_n;
    end
`else
    localparam logic [CW-1:0] DropUnusedN = CW'(DROP_N);
    logic w_unused_drop;
    assign w_unused_drop = ^DropUnusedN;
    assign w_drop_now    = 1'b0;
`endif

    // Next state and datapath updates, then output lookahead keyed on the next state
    always_comb begin
        w_state_n    = r_state;
        w_i_n        = r_i;
        w_j_n        = r_j;
        w_si_n       = r_si;
        w_t_n        = r_t;
        w_cnt_n      = r_cnt;
        w_len_n      = r_len;
        w_ks_data_n  = r_ks_data;
        w_ks_valid_n = r_ks_valid;
        w_rd_addr_n  = r_rd_addr;
        w_addr_a_n   = r_addr_a;
        w_addr_b_n   = r_addr_b;
        w_swap_n     = 1'b0;
        w_done_n     = r_done;

        case (r_state)
            ST_IDLE: begin
                w_i_n   = '0;
                w_j_n   = '0;
                w_cnt_n = '0;
                if (io_bus.ksa_done) begin
                    w_len_n   = io_bus.ks_len;
                    w_state_n = (io_bus.ks_len == '0) ? ST_DONE : ST_I;
                end
            end
            ST_I: begin
                w_i_n     = r_i + BW'(1);
                w_state_n = ST_J;
            end
            ST_J: begin
                w_si_n    = io_bus.S_rd_data;
                w_j_n     = r_j + io_bus.S_rd_data;
                w_state_n = ST_JR;
            end
            ST_JR:   w_state_n = ST_SWAP;
            ST_SWAP: begin
                w_t_n     = r_si + io_bus.S_rd_data;
                w_state_n = ST_T;
            end
            ST_T:    w_state_n = ST_K;
            ST_K: begin
                w_ks_data_n = io_bus.S_rd_data;
                if (w_drop_now) begin
                    w_state_n = ST_I;
                end else begin
                    w_ks_valid_n = 1'b1;
                    w_state_n    = ST_OUT;
                end
            end
            ST_OUT: begin
                if (io_bus.ks_ready) begin
                    w_ks_valid_n = 1'b0;
                    w_cnt_n      = r_cnt + CW'(1);
                    w_state_n    = ((r_cnt + CW'(1)) == r_len) ? ST_DONE : ST_I;
                end
            end
            ST_DONE: w_state_n = ST_DONE;
            default: w_state_n = ST_IDLE;
        endcase

        // Outputs are registered, so they are computed for the state being entered
        case (w_state_n)
            ST_I:    w_rd_addr_n = w_i_n + BW'(1);
            ST_JR:   w_rd_addr_n = w_j_n;
            ST_SWAP: begin
                w_swap_n   = 1'b1;
                w_addr_a_n = w_i_n;
                w_addr_b_n = w_j_n;
            end
            ST_T:    w_rd_addr_n = w_t_n;
            ST_DONE: w_done_n    = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_i        <= '0;
            r_j        <= '0;
            r_si       <= '0;
            r_t        <= '0;
            r_cnt      <= '0;
            r_len      <= '0;
            r_ks_data  <= '0;
            r_ks_valid <= 1'b0;
            r_rd_addr  <= '0;
            r_addr_a   <= '0;
            r_addr_b   <= '0;
            r_swap     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_i        <= w_i_n;
            r_j        <= w_j_n;
            r_si       <= w_si_n;
            r_t        <= w_t_n;
            r_cnt      <= w_cnt_n;
            r_len      <= w_len_n;
            r_ks_data  <= w_ks_data_n;
            r_ks_valid <= w_ks_valid_n;
            r_rd_addr  <= w_rd_addr_n;
            r_addr_a   <= w_addr_a_n;
            r_addr_b   <= w_addr_b_n;
            r_swap     <= w_swap_n;
            r_done     <= w_done_n;
        end
    end

    assign io_bus.S_rd_addr = r_rd_addr;
    assign io_bus.S_addr_a  = r_addr_a;
    assign io_bus.S_addr_b  = r_addr_b;
    assign io_bus.S_swap    = r_swap;
    assign io_bus.ks_data   = r_ks_data;
    assign io_bus.ks_valid  = r_ks_valid;
    assign io_bus.prga_done = r_done;
endmodule

// File: tb/tb_rc4_prga.sv
// Bench for rc4_prga: S-box memory model plus a plain-array golden RC4 generator.
module tb_rc4_prga;
`ifdef RC4_DROP_EN
    localparam int DROP = 2;
`else
    localparam int DROP = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rc4_prga_if bus ();
    rc4_prga #(.DROP_N(2)) dut (.clk(clk), .rst(rst), .io_bus(bus));

    // S-box memory with 1-cycle read and swap-at-edge
    logic [7:0] mem [256];
    logic [7:0] img [256];
    logic       load_en;
    always @(posedge clk) begin
        if (load_en) mem <= img;
        else if (bus.S_swap) begin
            mem[bus.S_addr_a] <= mem[bus.S_addr_b];
            mem[bus.S_addr_b] <= mem[bus.S_addr_a];
        end
        bus.S_rd_data <= mem[bus.S_rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Stream monitor, sampled on the falling edge
    logic [7:0] got_q [$];
    int         rise_q [$];
    int         swap_cnt = 0;
    int         stall_obs = 0;
    int         done_cyc = -1;
    logic       prev_stall = 1'b0, prev_valid = 1'b0, prev_done = 1'b0;
    logic [7:0] prev_data = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(bus.ks_valid), 32'd1);
                check("hold_data", 32'(bus.ks_data), 32'(prev_data));
                stall_obs++;
            end
            if (bus.ks_valid && !prev_valid) rise_q.push_back(cyc);
            if (bus.prga_done && !prev_done) done_cyc = cyc;
            if (bus.S_swap) swap_cnt++;
            if (bus.ks_valid && bus.ks_ready) got_q.push_back(bus.ks_data);
            prev_stall = bus.ks_valid && !bus.ks_ready;
            prev_data  = bus.ks_data;
            prev_valid = bus.ks_valid;
            prev_done  = bus.prga_done;
        end
    end

    // Golden RC4 state
    logic [7:0] ref_s [256];
    logic [7:0] ri, rj;
    logic [7:0] exp_q [$];

    task automatic ref_next(output logic [7:0] b);
        logic [7:0] tmp;
        logic [7:0] idx;
        ri  = ri + 8'd1;
        rj  = rj + ref_s[ri];
        tmp = ref_s[ri];
        ref_s[ri] = ref_s[rj];
        ref_s[rj] = tmp;
        idx = ref_s[ri] + ref_s[rj];
        b   = ref_s[idx];
    endtask

    task automatic load_sbox(input bit ident);
        logic [7:0] tmp;
        for (int k = 0; k < 256; k++) img[k] = 8'(k);
        if (!ident) begin
            for (int k = 255; k > 0; k--) begin
                int r;
                r = int'($urandom_range(k, 0));
                tmp = img[k]; img[k] = img[r]; img[r] = tmp;
            end
        end
        load_en = 1'b1;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    int gb, rb, sb, stb, start_cyc;

    // mode 0: ready high, 1: random ready, 2: ready low 10 cycles during byte 2
    task automatic start_and_wait(input int len, input int mode);
        logic [7:0] b;
        int budget, stall, diff;
        for (int k = 0; k < 256; k++) ref_s[k] = mem[k];
        ri = '0; rj = '0;
        for (int d = 0; d < DROP; d++) ref_next(b);
        exp_q.delete();
        for (int n = 0; n < len; n++) begin
            ref_next(b);
            exp_q.push_back(b);
        end
        gb = got_q.size(); rb = rise_q.size(); sb = swap_cnt; stb = stall_obs;
        bus.ks_len   = 16'(len);
        bus.ksa_done = 1'b1;
        bus.ks_ready = 1'b1;
        start_cyc    = cyc;
        budget = 30 * (len + DROP) + 50;
        stall  = 0;
        for (int c = 0; c < budget && !bus.prga_done; c++) begin
            @(posedge clk); #1;
            bus.ksa_done = 1'b0;
            case (mode)
                1: bus.ks_ready = 1'($urandom_range(1, 0));
                2: begin
                    if (got_q.size() - gb == 1 && stall < 10) begin
                        bus.ks_ready = 1'b0;
                        if (bus.ks_valid) stall++;
                    end else bus.ks_ready = 1'b1;
                end
                default: bus.ks_ready = 1'b1;
            endcase
        end
        @(negedge clk);
        check("done_reached", 32'(bus.prga_done), 32'd1);
        check("byte_count", 32'(got_q.size() - gb), 32'(len));
        for (int n = 0; n < len && gb + n < got_q.size(); n++)
            check("ks_byte", 32'(got_q[gb + n]), 32'(exp_q[n]));
        check("swap_count", 32'(swap_cnt - sb), (len == 0) ? 32'd0 : 32'(len + DROP));
        diff = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== ref_s[k]) diff++;
        check("sbox_state", 32'(diff), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] id3 [3];
        id3[0] = 8'h02; id3[1] = 8'h05; id3[2] = 8'h07;
        rst = 1'b1; load_en = 1'b0;
        bus.ksa_done = 1'b0; bus.ks_len = '0; bus.ks_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ks_valid", 32'(bus.ks_valid), 32'd0);
        check("rst_ks_data", 32'(bus.ks_data), 32'd0);
        check("rst_swap", 32'(bus.S_swap), 32'd0);
        check("rst_rd_addr", 32'(bus.S_rd_addr), 32'd0);
        check("rst_addr_ab", 32'({bus.S_addr_a, bus.S_addr_b}), 32'd0);
        check("rst_done", 32'(bus.prga_done), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Identity S-box, three bytes, ready tied high
        load_sbox(1'b1);
        start_and_wait(3, 0);
`ifndef RC4_DROP_EN
        for (int n = 0; n < 3 && gb + n < got_q.size(); n++)
            check("ident_byte", 32'(got_q[gb + n]), 32'(id3[n]));
        if (rise_q.size() - rb >= 2) begin
            check("first_latency", 32'(rise_q[rb] - start_cyc), 32'd7);
            check("byte_period", 32'(rise_q[rb + 1] - rise_q[rb]), 32'd7);
        end else check("valid_pulses", 32'(rise_q.size() - rb), 32'd3);
        check("done_time", 32'(done_cyc - start_cyc), 32'd22);
`endif
        pulse_reset();

        // Back-pressure during byte 2
        load_sbox(1'b1);
        start_and_wait(3, 2);
        check("stall_cycles", 32'(stall_obs - stb), 32'd10);
        pulse_reset();

        // Zero-length request
        load_sbox(1'b1);
        start_and_wait(0, 0);
        check("len0_no_valid", 32'(rise_q.size() - rb), 32'd0);
        check("len0_done_time", 32'(done_cyc - start_cyc), 32'd1);
        pulse_reset();

        // Long run across i wrap, random back-pressure
        load_sbox(1'b0);
        start_and_wait(300, 1);
        pulse_reset();

        // Abort while a byte is pending, then restart on current memory
        load_sbox(1'b0);
        bus.ks_ready = 1'b0; bus.ks_len = 16'd5; bus.ksa_done = 1'b1;
        for (int c = 0; c < 60 && !bus.ks_valid; c++) begin
            @(posedge clk); #1;
            bus.ksa_done = 1'b0;
        end
        bus.ksa_done = 1'b0;
        check("abort_pending", 32'(bus.ks_valid), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        pulse_reset();
        check("abort_valid", 32'(bus.ks_valid), 32'd0);
        check("abort_done", 32'(bus.prga_done), 32'd0);
        check("abort_swap", 32'(bus.S_swap), 32'd0);
        start_and_wait(1, 0);
        pulse_reset();

`ifdef RC4_DROP_EN
        load_sbox(1'b1);
        start_and_wait(1, 0);
        if (got_q.size() > gb) check("drop_byte", 32'(got_q[gb]), 32'h07);
        pulse_reset();
`endif

        // Random permutations and lengths
        for (int t = 0; t < 4; t++) begin
            load_sbox(1'b0);
            start_and_wait(int'($urandom_range(20, 1)), 1);
            pulse_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rc4_prga.md
# rc4_prga

RC4 pseudo-random generation stage that directly follows key scheduling. Once `ksa_done` asserts, it takes over the shared S-box memory and walks the i/j indices with swaps. It emits `ks_len` keystream bytes on a valid/ready stream for the downstream XOR stage, then raises `prga_done`.

## Interface
- `DROP_N`, default 256: number of leading keystream bytes discarded when `RC4_DROP_EN` is defined; range 1..65535.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ksa_done` in 1: level; a high level in IDLE starts generation.
- `ks_len` in 16: number of bytes to output; sampled on the cycle that leaves IDLE.
- `S_rd_addr` out 8: S-box read address; the S-box memory has 1-cycle synchronous read.
- `S_rd_data` in 8: S[`S_rd_addr`] from the previous cycle.
- `S_addr_a`, `S_addr_b` out 8: swap addresses.
- `S_swap` out 1: memory swaps S[a] and S[b] at the end of this cycle.
- `ks_data` out 8: keystream byte.
- `ks_valid` out 1: `ks_data` valid.
- `ks_ready` in 1: consumer accepts the byte.
- `prga_done` out 1: all requested bytes delivered.

## Operation
- Registers:
  - i, j (8-bit, mod 256);
  - si (8-bit);
  - t (8-bit);
  - byte counter cnt (16-bit);
  - len (16-bit);
  - drop counter (16-bit; present only with the macro).
- The state machine is registered, and all outputs derive from registers or the current state.
- States:
  - IDLE: i=j=0, cnt=0. On `ksa_done`=1, latch len=`ks_len`. Go to DONE if `ks_len`==0, else S_I.
  - S_I: i <= i+1. `S_rd_addr` = i+1. Go to S_J.
  - S_J: si <= `S_rd_data`; j <= j + `S_rd_data` (mod 256). Go to S_JR.
  - S_JR: `S_rd_addr` = j. Go to SWAP.
  - SWAP: `S_swap`=1, `S_addr_a`=i, `S_addr_b`=j; t <= si + `S_rd_data` (mod 256). Go to S_T.
  - S_T: `S_rd_addr` = t (the memory already reflects the swap). Go to S_K.
  - S_K: `ks_data` <= `S_rd_data`. If the byte is being dropped, decrement the drop counter and go to S_I. Otherwise set `ks_valid` <= 1 and go to OUT.
  - OUT: hold `ks_data` and `ks_valid`. On `ks_ready`: `ks_valid` <= 0, cnt <= cnt+1. If cnt+1==len go to DONE, else S_I.
  - DONE: `prga_done`=1 and `S_swap`=0. Stay here until `rst`; `ksa_done` is ignored.
- i==i==j swap (same address) is legal; the memory model makes it a no-op.
- i wraps 255→0 and j wraps mod 256 with no special handling. len up to 65535 spans many wraps.
- Outside SWAP, `S_swap`=0 and `S_addr_a`/`S_addr_b` hold their last values. `S_rd_addr` is don't-care in states where it is not listed.
- `ks_data` must not change while `ks_valid`=1 and `ks_ready`=0.

## Timing
- Reset values:
  - state IDLE;
  - i=j=si=t=cnt=0;
  - `ks_valid`=0, `ks_data`=0;
  - `S_swap`=0, `S_rd_addr`=0, `S_addr_a`=`S_addr_b`=0;
  - `prga_done`=0.
- `rst` mid-operation aborts generation. The next cycle is IDLE with all reset values, including `ks_valid`=0 even while a byte is pending. A partially completed swap is not undone.
- Latency: 6 cycles from leaving IDLE to the first `ks_valid` (S_I..S_K). With `ks_ready` tied high, throughput is 1 byte per 7 cycles and `ks_valid` pulses for 1 cycle.
- Handshake: a byte transfers on a rising edge with `ks_valid`=1 and `ks_ready`=1. `ks_ready` may toggle arbitrarily, and no byte is lost or duplicated.
- `prga_done` rises the cycle after the last handshake, or 1 cycle after IDLE exit when `ks_len`==0.

## Configuration
- `RC4_DROP_EN` defined:
  - the drop counter loads `DROP_N` on IDLE exit;
  - the first `DROP_N` generated bytes are computed (swaps happen) but never presented;
  - dropped bytes do not count toward len.
- Not defined: no drop counter, and every generated byte is presented.

## Test plan
- Bench S-box preloaded S[x]=x, `ks_len`=3, `ks_ready`=1 → `ks_data` 0x02, 0x05, 0x07. First `ks_valid` 6 cycles after start, then one every 7 cycles. `prga_done` follows the third byte.
- Same preload, `ks_ready` low for 10 cycles during byte 2 → 0x05 held stable with `ks_valid`=1. It is accepted once when ready rises, with no duplicates.
- `ks_len`=0 → no `S_swap`, no `ks_valid`, and `prga_done`=1 one cycle after `ksa_done`.
- `ks_len`=300 → exactly 300 handshakes. i passes 255→0, matching a golden RC4 model from the same S-box.
- `rst` pulsed while in OUT with byte pending → next cycle `ks_valid`=0, state IDLE. A restart with `ks_len`=1 outputs the correct byte for the current memory contents.
- `RC4_DROP_EN` with `DROP_N`=2, identity preload, `ks_len`=1 → the single output byte is 0x07 (bytes 1-2 dropped), and `S_swap` pulses 3 times.
